// File: rtl/wr_ptr_full_ctrl.sv
// Write-domain pointer and flag controller for an async FIFO. It synchronizes the read
// pointer, advances the gray write pointer, and produces full, almost-full, level and overflow.
module wr_ptr_full_ctrl #(
  parameter int ADDR_SIZE   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic [ADDR_SIZE:0]   rd_gray_ptr,
  input  logic                 wr_inc,
  input  logic [ADDR_SIZE:0]   wr_afull_thresh,
  input  logic                 wr_ovf_clr,
  output logic                 wr_en_mem,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE:0]   wr_ptr,
  output logic                 wr_full,
  output logic                 wr_afull,
  output logic [ADDR_SIZE:0]   wr_level,
  output logic                 wr_overflow
);

  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] rq [SYNC_STAGES];
  logic [PW-1:0] rq_g;
  logic [PW-1:0] rq_bin;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] wr_gray_next;
  logic [PW-1:0] full_match;
  logic [PW-1:0] level_next;
  logic          push;

  // Plain flop chain for the asynchronous read pointer; nothing may sit between stages.
  // NOTE: the synchronizer array is reset like any other register so the first compare after
  // reset sees a known pointer; this is a handful of flops, not a RAM.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) rq[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage take its neighbour's old value.
      rq[0] <= rd_gray_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) rq[i] <= rq[i-1];
    end
  end

  assign rq_g = rq[SYNC_STAGES-1];

  // Gray to binary: each bit is the XOR of itself and every more-significant gray bit.
  always_comb begin
    // NOTE: default assignment first so no path through the loop leaves a bit unassigned.
    rq_bin            = '0;
    rq_bin[ADDR_SIZE] = rq_g[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) rq_bin[i] = rq_bin[i+1] ^ rq_g[i];
  end

  assign push         = wr_inc & ~wr_full;
  assign wr_bin_next  = wr_bin + {{ADDR_SIZE{1'b0}}, push};
  assign wr_gray_next = (wr_bin_next >> 1) ^ wr_bin_next;
  // Full when the write pointer is one lap ahead: top two gray bits inverted, rest equal.
  assign full_match   = {~rq_g[ADDR_SIZE:ADDR_SIZE-1], rq_g[ADDR_SIZE-2:0]};
  assign level_next   = wr_bin_next - rq_bin;

  assign wr_en_mem = push;
  assign wr_addr   = wr_bin[ADDR_SIZE-1:0];

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_bin      <= '0;
      wr_ptr      <= '0;
      wr_full     <= 1'b0;
      wr_afull    <= 1'b0;
      wr_level    <= '0;
      wr_overflow <= 1'b0;
    end else begin
      wr_bin   <= wr_bin_next;
      wr_ptr   <= wr_gray_next;
      wr_full  <= (wr_gray_next == full_match);
      wr_level <= level_next;
      wr_afull <= (level_next >= wr_afull_thresh);
      // A write attempt while full wins over a clear arriving in the same cycle.
      if (wr_inc && wr_full) wr_overflow <= 1'b1;
      else if (wr_ovf_clr)   wr_overflow <= 1'b0;
    end
  end

endmodule
